// File: rtl/alu_cmd_driver.sv
// Command/response initiator for the 4-bit ALU core, one transaction in flight.
// Optional result self-check is enabled by defining ALU_DRV_CHECK_EN.
module alu_cmd_driver #(
    parameter int unsigned LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_err,
    output logic       chk_mismatch
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       err_q;
    logic       accept;
    logic       capture;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_ready && cmd_valid;
    assign capture   = (state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (cmd_valid) state_nx = WAIT;
            WAIT: if (cnt == 4'd0) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands stay on the bus after a transaction; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_op     <= 2'b00;
            err_q      <= 1'b0;
            cnt        <= 4'd0;
            rsp_result <= 8'h00;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_a  <= cmd_a;
                alu_b  <= cmd_b;
                alu_op <= cmd_op;
                err_q  <= (cmd_op == 2'b11) && (cmd_b == 4'd0);
                cnt    <= 4'(LATENCY);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_err    <= err_q;
            end
        end
    end

`ifdef ALU_DRV_CHECK_EN
    function automatic logic [7:0] ref_alu(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [1:0] op
    );
        logic [7:0] r;
        r = 8'h00;
        unique case (op)
            2'b00: r = {4'd0, a} + {4'd0, b};
            2'b01: r = {4'd0, a} - {4'd0, b};
            2'b10: r = {4'd0, a} * {4'd0, b};
            2'b11: r = (b == 4'd0) ? 8'hFF : {4'd0, a / b};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [7:0] exp_result;
    assign exp_result = ref_alu(alu_a, alu_b, alu_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_mismatch <= 1'b0;
        end else if (capture && (alu_result != exp_result)) begin
            chk_mismatch <= 1'b1;
        end
    end
`else
    assign chk_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a registered ALU model.
// Expected responses are queued at issue time and popped on each handshake.
module tb_alu_cmd_driver;

    localparam int unsigned LAT = 1;
`ifdef ALU_DRV_CHECK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_err;
    logic       chk_mismatch;
    logic       force_zero;

    int tests = 0;
    int fails = 0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    alu_cmd_driver #(.LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .cmd_op(cmd_op),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_err(rsp_err),
        .chk_mismatch(chk_mismatch)
    );

    // Registered ALU with one cycle of latency
    always @(posedge clk) begin
        if (force_zero) alu_result <= 8'h00;
        else begin
            case (alu_op)
                2'b00: alu_result <= {4'd0, alu_a} + {4'd0, alu_b};
                2'b01: alu_result <= {4'd0, alu_a} - {4'd0, alu_b};
                2'b10: alu_result <= {4'd0, alu_a} * {4'd0, alu_b};
                default: alu_result <= (alu_b == 4'd0) ? 8'hFF
                                       : {4'd0, alu_a / alu_b};
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake pops one expected entry
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {23'd0, rsp_err, rsp_result}, 32'h1ff);
            end else begin
                automatic logic [8:0] e = sb_q.pop_front();
                chk("rsp_result", 32'(rsp_result), 32'(e[8:1]));
                chk("rsp_err", 32'(rsp_err), 32'(e[0]));
            end
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input bit push,
                         input logic [7:0] res, input logic err);
        int n;
        if (push) sb_q.push_back({res, err});
        @(negedge clk);
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Edges after the accepting edge until RESP: LATENCY+1 WAIT cycles
    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_latency", 32'(n), 32'(LAT + 1));
    endtask

    task automatic done_rsp();
        @(posedge clk);
        #1;
        chk("ready_after_rsp", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [7:0] res,
                       input logic err);
        issue(a, b, op, 1'b1, res, err);
        wait_rsp();
        done_rsp();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_alu", {22'd0, alu_a, alu_b, alu_op}, 32'd0);
        chk("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_result}, 32'd0);
        chk("rst_chk", 32'(chk_mismatch), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = 4'd0;
        cmd_b = 4'd0;
        cmd_op = 2'b00;
        rsp_ready = 1'b1;
        force_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs();

        run(4'd7, 4'd9, 2'b00, 8'h10, 1'b0);
        run(4'd3, 4'd5, 2'b01, 8'hFE, 1'b0);
        run(4'd0, 4'd1, 2'b01, 8'hFF, 1'b0);
        run(4'd9, 4'd0, 2'b11, 8'hFF, 1'b1);
        run(4'd9, 4'd2, 2'b11, 8'h04, 1'b0);
        run(4'd15, 4'd15, 2'b10, 8'hE1, 1'b0);
        run(4'd15, 4'd15, 2'b00, 8'h1E, 1'b0);
        chk("alu_held", {24'd0, alu_a, alu_b}, 32'hFF);

        // Stall in RESP while a new command waits
        rsp_ready = 1'b0;
        issue(4'd9, 4'd0, 2'b11, 1'b1, 8'hFF, 1'b1);
        wait_rsp();
        cmd_a = 4'd1;
        cmd_b = 4'd1;
        cmd_op = 2'b00;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_hold", {21'd0, rsp_valid, cmd_ready, rsp_err,
                rsp_result}, {21'd0, 3'b101, 8'hFF});
        end
        chk("stall_alu", {24'd0, alu_a, alu_b}, 32'h90);
        sb_q.push_back({8'h02, 1'b0});
        rsp_ready = 1'b1;
        done_rsp();
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp();
        done_rsp();

        // Reset in the middle of WAIT drops the transaction
        issue(4'd5, 4'd5, 2'b00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs();
        repeat (5) @(posedge clk);
        #1 chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        run(4'd2, 4'd3, 2'b10, 8'h06, 1'b0);

        // Corrupted ALU result trips the optional checker
        force_zero = 1'b1;
        run(4'd1, 4'd1, 2'b00, 8'h00, 1'b0);
        force_zero = 1'b0;
        chk("chk_set", 32'(chk_mismatch), 32'(CHK_ON));
        run(4'd4, 4'd2, 2'b11, 8'h02, 1'b0);
        chk("chk_sticky", 32'(chk_mismatch), 32'(CHK_ON));
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("chk_cleared", 32'(chk_mismatch), 32'd0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
